// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register for the 5-stage MIPS core.
// It carries decoded operands, register addresses and control bits from ID to EX.
// It also detects load-use hazards. On a hazard it inserts one bubble and asks
// PC and IF/ID to hold. It further supports a branch flush and a debug freeze.
module id_ex_latch #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_ALUOP = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_pc4,
    input  logic [NB_DATA-1:0]  i_rs_data,
    input  logic [NB_DATA-1:0]  i_rt_data,
    input  logic [NB_DATA-1:0]  i_imm,
    input  logic [NB_REG-1:0]   i_rs,
    input  logic [NB_REG-1:0]   i_rt,
    input  logic [NB_REG-1:0]   i_rd,
    input  logic                i_reg_dst,
    input  logic                i_alu_src,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic                i_mem_to_reg,
    input  logic                i_reg_write,
    input  logic                i_halt,
    input  logic [NB_ALUOP-1:0] i_alu_op,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_pc4,
    output logic [NB_DATA-1:0]  o_rs_data,
    output logic [NB_DATA-1:0]  o_rt_data,
    output logic [NB_DATA-1:0]  o_imm,
    output logic [NB_REG-1:0]   o_rs,
    output logic [NB_REG-1:0]   o_rt,
    output logic [NB_REG-1:0]   o_rd,
    output logic                o_reg_dst,
    output logic                o_alu_src,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_mem_to_reg,
    output logic                o_reg_write,
    output logic                o_halt,
    output logic [NB_ALUOP-1:0] o_alu_op,
    output logic                o_stall,
    output logic [15:0]         o_bubble_cnt
);

    logic hz;
    logic bubble;

    // Load-use hazard: the load in EX writes a register that the ID instruction reads.
    // rt is a source only for R-type instructions (reg_dst) and for stores.
    always_comb begin
        hz = o_mem_read & o_valid & (o_rt != '0)
           & ((o_rt == i_rs) | ((o_rt == i_rt) & (i_reg_dst | i_mem_write)))
           & i_valid;
    end

    // A flush already squashes the instruction in ID, so no stall is needed.
    assign o_stall = hz & ~i_flush;
    assign bubble  = i_flush | hz;

    // Data and address fields always advance when enabled; in a bubble they are don't-care.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            o_pc4     <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_reg_dst <= 1'b0;
            o_alu_src <= 1'b0;
        end else if (i_enable) begin
            o_pc4     <= i_pc4;
            o_rs_data <= i_rs_data;
            o_rt_data <= i_rt_data;
            o_imm     <= i_imm;
            o_rs      <= i_rs;
            o_rt      <= i_rt;
            o_rd      <= i_rd;
            o_reg_dst <= i_reg_dst;
            o_alu_src <= i_alu_src;
        end
    end

    // Control bits with side effects are cleared whenever a bubble is inserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_reg_write  <= 1'b0;
            o_halt       <= 1'b0;
            o_alu_op     <= '0;
        end else if (i_enable) begin
            if (bubble) begin
                o_valid      <= 1'b0;
                o_mem_read   <= 1'b0;
                o_mem_write  <= 1'b0;
                o_mem_to_reg <= 1'b0;
                o_reg_write  <= 1'b0;
                o_halt       <= 1'b0;
                o_alu_op     <= '0;
            end else begin
                o_valid      <= i_valid;
                o_mem_read   <= i_mem_read;
                o_mem_write  <= i_mem_write;
                o_mem_to_reg <= i_mem_to_reg;
                o_reg_write  <= i_reg_write;
                o_halt       <= i_halt;
                o_alu_op     <= i_alu_op;
            end
        end
    end

    // Count only hazard bubbles, not flushes. The count saturates at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bubble_cnt <= '0;
        end else if (i_enable && o_stall && (o_bubble_cnt != 16'hFFFF)) begin
            o_bubble_cnt <= o_bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed tests for the ID/EX register and its load-use hazard logic.
module tb_id_ex_latch;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_flush;
    logic        i_valid;
    logic [31:0] i_pc4;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic [31:0] i_imm;
    logic [4:0]  i_rs;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic        i_reg_dst;
    logic        i_alu_src;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic        i_reg_write;
    logic        i_halt;
    logic [3:0]  i_alu_op;
    logic        o_valid;
    logic [31:0] o_pc4;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_imm;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic        o_reg_dst;
    logic        o_alu_src;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_mem_to_reg;
    logic        o_reg_write;
    logic        o_halt;
    logic [3:0]  o_alu_op;
    logic        o_stall;
    logic [15:0] o_bubble_cnt;

    int n_pass  = 0;
    int n_total = 0;

    id_ex_latch #(.NB_DATA(32), .NB_REG(5), .NB_ALUOP(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_flush(i_flush),
        .i_valid(i_valid), .i_pc4(i_pc4), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_reg_dst(i_reg_dst),
        .i_alu_src(i_alu_src), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write), .i_halt(i_halt),
        .i_alu_op(i_alu_op), .o_valid(o_valid), .o_pc4(o_pc4), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
        .o_halt(o_halt), .o_alu_op(o_alu_op), .o_stall(o_stall), .o_bubble_cnt(o_bubble_cnt)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Quiet ID stage: no instruction, pipeline enabled, no flush.
    task automatic set_idle();
        i_enable = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
        i_pc4 = '0; i_rs_data = '0; i_rt_data = '0; i_imm = '0;
        i_rs = '0; i_rt = '0; i_rd = '0;
        i_reg_dst = 1'b0; i_alu_src = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_mem_to_reg = 1'b0; i_reg_write = 1'b0; i_halt = 1'b0; i_alu_op = '0;
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a load "lw rt, (rs)" into ID.
    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        set_idle();
        i_valid = 1'b1; i_rs = rs; i_rt = rt; i_mem_read = 1'b1;
        i_mem_to_reg = 1'b1; i_reg_write = 1'b1; i_alu_src = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        set_idle();
        #12 i_rst_n = 1'b1;
        // Make all inputs 1 except flush so the registers pick up non-zero values.
        i_enable = 1'b1; i_flush = 1'b0; i_valid = 1'b1;
        i_pc4 = '1; i_rs_data = '1; i_rt_data = '1; i_imm = '1;
        i_rs = '1; i_rt = '1; i_rd = '1;
        i_reg_dst = 1'b1; i_alu_src = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b1;
        i_mem_to_reg = 1'b1; i_reg_write = 1'b1; i_halt = 1'b1; i_alu_op = '1;
        step();
        n_total++; if (o_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", o_valid); else n_pass++;
        step();  // the load of $31 now stalls the same instruction: one bubble
        n_total++; if (o_bubble_cnt !== 16'd1) $display("FAIL pre_reset_cnt: got %0d want 1", o_bubble_cnt); else n_pass++;
        i_flush = 1'b1;
        #3 i_rst_n = 1'b0;  // mid-cycle, well away from any edge
        #1;
        n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
        n_total++; if (o_pc4 !== 32'd0) $display("FAIL reset_pc4: got %h want 0", o_pc4); else n_pass++;
        n_total++; if (o_rs_data !== 32'd0 || o_rt_data !== 32'd0 || o_imm !== 32'd0)
            $display("FAIL reset_data: got %h %h %h want 0", o_rs_data, o_rt_data, o_imm); else n_pass++;
        n_total++; if (o_rs !== 5'd0 || o_rt !== 5'd0 || o_rd !== 5'd0)
            $display("FAIL reset_regs: got %0d %0d %0d want 0", o_rs, o_rt, o_rd); else n_pass++;
        n_total++; if ({o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write, o_halt} !== 7'd0)
            $display("FAIL reset_ctrl: got %b want 0", {o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write, o_halt}); else n_pass++;
        n_total++; if (o_alu_op !== 4'd0) $display("FAIL reset_alu_op: got %0d want 0", o_alu_op); else n_pass++;
        n_total++; if (o_bubble_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", o_bubble_cnt); else n_pass++;
        n_total++; if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall); else n_pass++;
        set_idle();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        set_idle();
        i_valid = 1'b1; i_rs = 5'd3; i_rt = 5'd4; i_rd = 5'd5; i_rs_data = 32'h11;
        i_rt_data = 32'h22; i_imm = 32'hFFFF_FFF0; i_pc4 = 32'h104;
        i_alu_op = 4'd2; i_reg_write = 1'b1; i_reg_dst = 1'b1;
        #1;
        n_total++; if (o_stall !== 1'b0) $display("FAIL pass_stall: got %b want 0", o_stall); else n_pass++;
        step();
        n_total++; if (o_rs !== 5'd3 || o_rt !== 5'd4 || o_rd !== 5'd5)
            $display("FAIL pass_regs: got %0d %0d %0d want 3 4 5", o_rs, o_rt, o_rd); else n_pass++;
        n_total++; if (o_rs_data !== 32'h11 || o_rt_data !== 32'h22)
            $display("FAIL pass_data: got %h %h want 11 22", o_rs_data, o_rt_data); else n_pass++;
        n_total++; if (o_imm !== 32'hFFFF_FFF0 || o_pc4 !== 32'h104)
            $display("FAIL pass_imm_pc4: got %h %h want fffffff0 104", o_imm, o_pc4); else n_pass++;
        n_total++; if (o_alu_op !== 4'd2 || o_reg_write !== 1'b1 || o_valid !== 1'b1 || o_reg_dst !== 1'b1)
            $display("FAIL pass_ctrl: got op=%0d rw=%b v=%b rd=%b want 2 1 1 1", o_alu_op, o_reg_write, o_valid, o_reg_dst); else n_pass++;
        n_total++; if (o_stall !== 1'b0) $display("FAIL pass_stall_after: got %b want 0", o_stall); else n_pass++;
    endtask

    task automatic test_load_use();
        drive_lw(5'd1, 5'd8);
        step();
        set_idle();
        i_valid = 1'b1; i_rs = 5'd8; i_rt = 5'd2; i_rd = 5'd3;
        i_reg_dst = 1'b1; i_reg_write = 1'b1; i_alu_op = 4'd2;
        #1;
        n_total++; if (o_stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", o_stall); else n_pass++;
        step();
        n_total++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_mem_read !== 1'b0 || o_mem_to_reg !== 1'b0)
            $display("FAIL lu_bubble: got v=%b rw=%b mr=%b m2r=%b want 0", o_valid, o_reg_write, o_mem_read, o_mem_to_reg); else n_pass++;
        n_total++; if (o_bubble_cnt !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", o_bubble_cnt); else n_pass++;
        n_total++; if (o_stall !== 1'b0) $display("FAIL lu_stall_drop: got %b want 0", o_stall); else n_pass++;
        step();
        n_total++; if (o_valid !== 1'b1 || o_rs !== 5'd8 || o_rd !== 5'd3 || o_reg_write !== 1'b1 || o_alu_op !== 4'd2)
            $display("FAIL lu_advance: got v=%b rs=%0d rd=%0d rw=%b op=%0d want 1 8 3 1 2", o_valid, o_rs, o_rd, o_reg_write, o_alu_op); else n_pass++;
        n_total++; if (o_bubble_cnt !== 16'd1) $display("FAIL lu_cnt_hold: got %0d want 1", o_bubble_cnt); else n_pass++;
    endtask

    task automatic test_no_stall_cases();
        // A load into $0 never stalls, even though the consumer reads $0.
        drive_lw(5'd2, 5'd0);
        step();
        set_idle();
        i_valid = 1'b1; i_rs = 5'd0; i_rt = 5'd0; i_reg_dst = 1'b1;
        #1;
        n_total++; if (o_stall !== 1'b0) $display("FAIL zero_reg_stall: got %b want 0", o_stall); else n_pass++;
        // Replace the consumer with a load of $9; it must not stall behind the $0 load.
        drive_lw(5'd0, 5'd9);
        step();
        set_idle();
        i_valid = 1'b1; i_rs = 5'd3; i_rt = 5'd9; i_rd = 5'd4;
        #1;
        n_total++; if (o_stall !== 1'b0) $display("FAIL nomatch_stall: got %b want 0", o_stall); else n_pass++;
        i_reg_dst = 1'b1;
        #1;
        n_total++; if (o_stall !== 1'b1) $display("FAIL rt_rtype_stall: got %b want 1", o_stall); else n_pass++;
        i_reg_dst = 1'b0; i_mem_write = 1'b1;
        #1;
        n_total++; if (o_stall !== 1'b1) $display("FAIL rt_store_stall: got %b want 1", o_stall); else n_pass++;
        i_valid = 1'b0;
        #1;
        n_total++; if (o_stall !== 1'b0) $display("FAIL invalid_id_stall: got %b want 0", o_stall); else n_pass++;
        i_valid = 1'b1; i_mem_write = 1'b0;
        step();
        n_total++; if (o_valid !== 1'b1 || o_rs !== 5'd3 || o_bubble_cnt !== 16'd1)
            $display("FAIL nomatch_advance: got v=%b rs=%0d cnt=%0d want 1 3 1", o_valid, o_rs, o_bubble_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        drive_lw(5'd1, 5'd7);
        step();
        set_idle();
        i_valid = 1'b1; i_rs = 5'd7; i_reg_write = 1'b1; i_flush = 1'b1;
        #1;
        n_total++; if (o_stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", o_stall); else n_pass++;
        step();
        n_total++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_mem_read !== 1'b0)
            $display("FAIL flush_bubble: got v=%b rw=%b mr=%b want 0", o_valid, o_reg_write, o_mem_read); else n_pass++;
        n_total++; if (o_bubble_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", o_bubble_cnt); else n_pass++;
        // Halt is squashed by a flush and propagates otherwise.
        set_idle();
        i_valid = 1'b1; i_halt = 1'b1; i_flush = 1'b1;
        step();
        n_total++; if (o_halt !== 1'b0) $display("FAIL flush_halt: got %b want 0", o_halt); else n_pass++;
        i_flush = 1'b0;
        step();
        n_total++; if (o_halt !== 1'b1 || o_valid !== 1'b1) $display("FAIL halt_pass: got h=%b v=%b want 1 1", o_halt, o_valid); else n_pass++;
    endtask

    task automatic test_freeze();
        drive_lw(5'd1, 5'd6);
        step();
        set_idle();
        i_valid = 1'b1; i_rs = 5'd6; i_rd = 5'd10; i_reg_write = 1'b1; i_alu_op = 4'd5;
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_pc4 = 32'h200 + 32'(k); i_rs_data = 32'hA0 + 32'(k); i_rd = 5'(11 + k);
            step();
            n_total++; if (o_mem_read !== 1'b1 || o_rt !== 5'd6 || o_valid !== 1'b1 || o_rs !== 5'd1)
                $display("FAIL freeze_hold_%0d: got mr=%b rt=%0d v=%b rs=%0d want 1 6 1 1", k, o_mem_read, o_rt, o_valid, o_rs); else n_pass++;
            n_total++; if (o_bubble_cnt !== 16'd1 || o_stall !== 1'b1)
                $display("FAIL freeze_cnt_stall_%0d: got cnt=%0d st=%b want 1 1", k, o_bubble_cnt, o_stall); else n_pass++;
        end
        i_enable = 1'b1;
        step();
        n_total++; if (o_valid !== 1'b0 || o_bubble_cnt !== 16'd2)
            $display("FAIL freeze_resume_bubble: got v=%b cnt=%0d want 0 2", o_valid, o_bubble_cnt); else n_pass++;
        step();
        n_total++; if (o_valid !== 1'b1 || o_rs !== 5'd6 || o_rd !== 5'd13 || o_alu_op !== 4'd5)
            $display("FAIL freeze_resume_adv: got v=%b rs=%0d rd=%0d op=%0d want 1 6 13 5", o_valid, o_rs, o_rd, o_alu_op); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_lw(5'd1, 5'd4);
        step();
        drive_lw(5'd4, 5'd5);  // depends on the first load
        #1;
        n_total++; if (o_stall !== 1'b1) $display("FAIL b2b_stall1: got %b want 1", o_stall); else n_pass++;
        step();
        n_total++; if (o_bubble_cnt !== 16'd3 || o_valid !== 1'b0)
            $display("FAIL b2b_bubble1: got cnt=%0d v=%b want 3 0", o_bubble_cnt, o_valid); else n_pass++;
        step();
        n_total++; if (o_mem_read !== 1'b1 || o_rt !== 5'd5 || o_valid !== 1'b1)
            $display("FAIL b2b_load2: got mr=%b rt=%0d v=%b want 1 5 1", o_mem_read, o_rt, o_valid); else n_pass++;
        set_idle();
        i_valid = 1'b1; i_rs = 5'd5; i_rt = 5'd1; i_reg_dst = 1'b1; i_reg_write = 1'b1;
        #1;
        n_total++; if (o_stall !== 1'b1) $display("FAIL b2b_stall2: got %b want 1", o_stall); else n_pass++;
        step();
        step();
        n_total++; if (o_bubble_cnt !== 16'd4 || o_valid !== 1'b1 || o_rs !== 5'd5 || o_stall !== 1'b0)
            $display("FAIL b2b_final: got cnt=%0d v=%b rs=%0d st=%b want 4 1 5 0", o_bubble_cnt, o_valid, o_rs, o_stall); else n_pass++;
    endtask

    // Directed scenarios in sequence, then the summary.
    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_stall_cases();
        test_flush();
        test_freeze();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
ID/EX pipeline register for the 5-stage MIPS core, with built-in load-use hazard detection. It captures decoded operands, register addresses and control bits from ID. It presents them to EX and to the forwarding unit (rs, rt, reg_dst, mem_write). It inserts a one-cycle bubble on a load-use hazard and tells PC and IF/ID to hold. It also supports branch flush and debug-unit freeze.

Parameters:
NB_DATA, 32, datapath width (operands, immediate, PC+4)
NB_REG, 5, register address width
NB_ALUOP, 4, ALU operation code width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  pipeline advance enable from debug unit; 0 = freeze
i_flush  in  1  taken branch/jump resolved; squash instruction entering EX
i_valid  in  1  ID holds a real instruction
i_pc4  in  NB_DATA  PC+4 of ID instruction
i_rs_data  in  NB_DATA  register file read port A
i_rt_data  in  NB_DATA  register file read port B
i_imm  in  NB_DATA  sign/zero-extended immediate
i_rs, i_rt, i_rd  in  NB_REG each  register addresses from ID
i_reg_dst, i_alu_src, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_halt  in  1 each  decoded control
i_alu_op  in  NB_ALUOP  ALU operation
o_valid  out  1  EX holds a real instruction
o_pc4, o_rs_data, o_rt_data, o_imm  out  NB_DATA  registered copies
o_rs, o_rt, o_rd  out  NB_REG  registered copies (feed forwarding unit)
o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write, o_halt  out  1  registered control
o_alu_op  out  NB_ALUOP  registered ALU op
o_stall  out  1  combinational; hold PC and IF/ID this cycle
o_bubble_cnt  out  16  saturating count of bubbles inserted (debug readout)

Behaviour:
- Reset (i_rst_n low, asynchronous): every registered output is 0 and o_bubble_cnt = 0. Effect is immediate, independent of clock, including mid-stall. Operation resumes on the first rising edge after release.
- Hazard, combinational: hz = o_mem_read & o_valid & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt & (i_reg_dst | i_mem_write))) & i_valid.
- o_stall = hz & ~i_flush. o_stall is also valid while i_enable = 0; it is computed from the held values.
- Per rising edge, in priority order:
  1. i_enable = 0: hold all registers and the counter.
  2. i_flush = 1: load bubble.
  3. hz = 1: load bubble; o_bubble_cnt += 1, saturating at 0xFFFF.
  4. Otherwise: load all i_* into o_*. o_valid <= i_valid.
- Bubble: o_valid, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg and o_halt = 0; o_alu_op = 0. Data and address fields load normally but are don't-care. Flush bubbles do not increment the counter.
- Latency: 1 cycle ID->EX.
- Load-use costs exactly one bubble: after the bubble, o_mem_read = 0, so hz drops and the held ID instruction advances on the next enabled edge.
- Back-to-back loads each stall at most once.
- Loads into $0 never stall.
- Flush and hazard in the same cycle: flush wins, o_stall = 0, and the counter does not increment.
- o_halt propagates like any control bit. It is squashed by flush or bubble.

Test Plan:
- Reset: drive all inputs to 1, i_rst_n=0 asynchronously mid-cycle -> all outputs 0 without waiting for a clock edge; o_bubble_cnt=0.
- Plain pass-through: i_valid=1, i_rs=3, i_rt=4, i_rd=5, i_rs_data=0x11, i_alu_op=2, i_reg_write=1 -> next edge o_rs=3, o_rt=4, o_rd=5, o_rs_data=0x11, o_alu_op=2, o_reg_write=1, o_stall=0.
- Load-use: EX holds lw with o_rt=8, o_mem_read=1; ID holds add with i_rs=8 -> o_stall=1. Next edge: o_valid=0, o_reg_write=0, o_bubble_cnt=1, o_stall=0. Following edge: the add is latched.
- $0 and non-matching loads: lw with o_rt=0 and i_rs=0, then lw with o_rt=9 and i_rs=3, i_rt=9, i_reg_dst=0, i_mem_write=0 -> o_stall=0 in both cases.
- Flush vs hazard: hazard condition plus i_flush=1 -> o_stall=0; next edge bubble; o_bubble_cnt unchanged.
- Freeze: i_enable=0 for 3 cycles with changing inputs -> outputs and counter frozen, o_stall still reflects the held hazard. Then i_enable=1 -> normal priority resumes.
